spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_rr_picker.sv | 42 ++++
 rtl/spi_arbiter.sv | 155 +++++++++++++++
 tb/tb_spi_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI arbiter slice: FSM state type, byte width
// and the largest supported requester count.
package spi_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NREQ_MAX = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin selector: first set request bit at or after the
// pointer, wrapping from NREQ-1 back to 0. Returns one-hot and index.
module spi_rr_picker
  import spi_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [2:0]      o_idx,
  output logic            o_any
);

  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_src;
  logic            w_found;

  assign o_any = |i_req;

  // Requests at/after the pointer take priority; otherwise wrap to the lowest.
  always_comb begin
    w_mask = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_mask[k] = (k >= 32'(i_ptr));
    end
    w_hi     = i_req & w_mask;
    w_src    = (w_hi != '0) ? w_hi : i_req;
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_found && w_src[k]) begin
        w_found     = 1'b1;
        o_onehot[k] = 1'b1;
        o_idx       = 3'(k);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters.
// Optional transfer timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*BYTE_W-1:0] req_data,
  output logic [NREQ-1:0]        grant,
  output logic                   rsp_valid,
  output logic [2:0]             rsp_id,
  output logic [BYTE_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   m_send,
  output logic [BYTE_W-1:0]      m_data,
  input  logic                   m_done,
  input  logic [BYTE_W-1:0]      m_rx,
  input  logic                   m_cs,
  output logic [NREQ-1:0]        ss_n
);

  arb_state_t        r_state;
  logic [2:0]        r_ptr;
  logic [2:0]        r_owner;
  logic [NREQ-1:0]   r_grant;
  logic              r_m_send;
  logic [BYTE_W-1:0] r_m_data;
  logic              r_rsp_valid;
  logic [2:0]        r_rsp_id;
  logic [BYTE_W-1:0] r_rsp_data;
  logic              r_done_q;

  logic [NREQ-1:0]   w_pick_oh;
  logic [2:0]        w_pick_idx;
  logic              w_pick_any;
  logic [BYTE_W-1:0] w_sel_data;
  logic [2:0]        w_ptr_next;
  logic              w_done_rise;

  spi_rr_picker #(.NREQ(NREQ)) u_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Byte of the requester the picker selected.
  always_comb begin
    w_sel_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_pick_oh[k]) w_sel_data = req_data[k*BYTE_W +: BYTE_W];
    end
  end

  assign w_ptr_next  = (w_pick_idx == 3'(NREQ - 1)) ? 3'd0 : w_pick_idx + 3'd1;
  assign w_done_rise = m_done & ~r_done_q;

  assign grant     = r_grant;
  assign m_send    = r_m_send;
  assign m_data    = r_m_data;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign ss_n      = {NREQ{m_cs}} | ~r_grant;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_err;
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  // Arbitration FSM with registered grant, master handshake and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_m_send    <= 1'b0;
      r_m_data    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_done_q    <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_done_q    <= m_done;
      r_m_send    <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_pick_any) begin
            r_grant  <= w_pick_oh;
            r_owner  <= w_pick_idx;
            r_m_data <= w_sel_data;
            r_ptr    <= w_ptr_next;
            r_m_send <= 1'b1;
            r_state  <= S_LAUNCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LAUNCH: begin
`ifdef SPI_ARB_TIMEOUT_EN
          r_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done edge outranks a timeout expiring in the same cycle.
          if (w_done_rise) begin
            r_rsp_data  <= m_rx;
            r_rsp_id    <= r_owner;
            r_rsp_valid <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            r_state     <= S_RESP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rsp_data  <= '0;
            r_rsp_id    <= r_owner;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter (NREQ=4, TIMEOUT=16).
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        m_send;
  logic [7:0]  m_data;
  logic        m_done;
  logic [7:0]  m_rx;
  logic        m_cs;
  logic [3:0]  ss_n;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned n_send   = 0;
  int unsigned n_rsp    = 0;
  int unsigned viol     = 0;
  logic [3:0]  prev_grant = '0;

  spi_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .m_send    (m_send),
    .m_data    (m_data),
    .m_done    (m_done),
    .m_rx      (m_rx),
    .m_cs      (m_cs),
    .ss_n      (ss_n)
  );

  always #5 clk = ~clk;

  // Pulse counters and grant invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_send === 1'b1) n_send++;
    if (rsp_valid === 1'b1) n_rsp++;
    if (!$onehot0(grant)) viol++;
    if (grant != 4'b0 && prev_grant != 4'b0 && grant != prev_grant) viol++;
    prev_grant = grant;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer; late is OR'd into req during WAIT, drop cleared in RESP.
  task automatic do_xfer(input int unsigned id, input logic [7:0] tx, input logic [7:0] rx,
                         input logic [3:0] late, input logic [3:0] drop);
    int unsigned n = 0;
    while (m_send !== 1'b1 && n < 8) begin tick(); n++; end
    chk("launch_seen", 32'(m_send), 32'd1);
    chk("grant_owner", 32'(grant), 32'(4'b0001 << id));
    chk("m_data", 32'(m_data), 32'(tx));
    tick();
    req = req | late;
    m_rx = rx;
    m_done = 1'b1;
    tick();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_data", 32'(rsp_data), 32'(rx));
    chk("rsp_err", 32'(rsp_err), 32'd0);
    chk("grant_in_resp", 32'(grant), 32'(4'b0001 << id));
    m_done = 1'b0;
    req = req & ~drop;
    tick();
    chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    chk("grant_clear", 32'(grant), 32'd0);
  endtask

  initial begin
    int unsigned s0;
    int unsigned r0;
    int unsigned n;
    rst = 1'b1; req = '0; req_data = '0; m_done = 1'b0; m_rx = '0; m_cs = 1'b1;
    tick(); tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_m_send", 32'(m_send), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_ss_n", 32'(ss_n), 32'hF);
    rst = 1'b0;
    tick();

    // Single requester 1: latency, select line, response.
    s0 = n_send;
    req = 4'b0010;
    req_data[15:8] = 8'hA5;
    tick();
    chk("arb_no_grant_yet", 32'(grant), 32'd0);
    chk("arb_no_send_yet", 32'(m_send), 32'd0);
    tick();
    chk("t1_grant", 32'(grant), 32'h2);
    chk("t1_m_send", 32'(m_send), 32'd1);
    chk("t1_m_data", 32'(m_data), 32'hA5);
    m_cs = 1'b0;
    #1;
    chk("t1_ss_n", 32'(ss_n), 32'hD);
    tick();
    chk("t1_send_pulse", 32'(m_send), 32'd0);
    chk("t1_m_data_held", 32'(m_data), 32'hA5);
    tick();
    chk("t1_no_rsp_early", 32'(rsp_valid), 32'd0);
    m_rx = 8'hA6;
    m_done = 1'b1;
    tick();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_id", 32'(rsp_id), 32'd1);
    chk("t1_rsp_data", 32'(rsp_data), 32'hA6);
    chk("t1_rsp_err", 32'(rsp_err), 32'd0);
    m_done = 1'b0; m_cs = 1'b1; req = '0;
    tick();
    chk("t1_idle_grant", 32'(grant), 32'd0);
    chk("t1_idle_ss_n", 32'(ss_n), 32'hF);
    chk("t1_one_send", 32'(n_send - s0), 32'd1);

    // All four requesting from pointer 0: order 0,1,2,3,0.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    req = 4'b1111;
    req_data = 32'h13121110;
    do_xfer(0, 8'h10, 8'h80, 4'b0000, 4'b0000);
    do_xfer(1, 8'h11, 8'h81, 4'b0000, 4'b0000);
    do_xfer(2, 8'h12, 8'h82, 4'b0000, 4'b0000);
    do_xfer(3, 8'h13, 8'h83, 4'b0000, 4'b0000);
    do_xfer(0, 8'h10, 8'h84, 4'b0000, 4'b1111);

    // Requester 2 arrives mid-transfer of requester 0 (pointer now 1).
    req = 4'b0001;
    req_data = 32'h00420040;
    do_xfer(0, 8'h40, 8'h50, 4'b0100, 4'b0001);
    do_xfer(2, 8'h42, 8'h52, 4'b0000, 4'b0100);

    // Reset in WAIT: no response, pointer back to 0.
    req = 4'b0010;
    req_data = 32'h23002100;
    tick(); tick();
    chk("t4_grant", 32'(grant), 32'h2);
    m_cs = 1'b0;
    tick();
    r0 = n_rsp;
    rst = 1'b1;
    m_done = 1'b1;
    #1;
    chk("t4_rst_grant", 32'(grant), 32'd0);
    chk("t4_rst_m_data", 32'(m_data), 32'd0);
    chk("t4_rst_m_send", 32'(m_send), 32'd0);
    chk("t4_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t4_rst_ss_n", 32'(ss_n), 32'hF);
    tick();
    rst = 1'b0; req = '0; m_done = 1'b0; m_cs = 1'b1;
    tick(); tick();
    chk("t4_no_rsp", 32'(n_rsp - r0), 32'd0);
    req = 4'b1010;
    do_xfer(1, 8'h21, 8'h31, 4'b0000, 4'b0010);
    do_xfer(3, 8'h23, 8'h33, 4'b0000, 4'b1000);

    // One-cycle pulse on req[3]: ARB finds nothing and returns to IDLE.
    s0 = n_send;
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_m_send", 32'(m_send), 32'd0);
    tick(); tick();
    chk("t5_no_send", 32'(n_send - s0), 32'd0);
    chk("t5_grant_idle", 32'(grant), 32'd0);

    // m_done already high at WAIT entry is not a completion.
    m_done = 1'b1;
    req = 4'b0001;
    req_data = 32'h0000005F;
    n = 0;
    while (m_send !== 1'b1 && n < 8) begin tick(); n++; end
    chk("t6_launch", 32'(m_send), 32'd1);
    tick(); tick(); tick();
    chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    m_done = 1'b0;
    tick();
    m_done = 1'b1;
    m_rx = 8'h5A;
    tick();
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t6_rsp_data", 32'(rsp_data), 32'h5A);
    m_done = 1'b0; req = '0;
    tick();

`ifdef SPI_ARB_TIMEOUT_EN
    // Timeout: m_done never rises; response 16 cycles after WAIT entry.
    req = 4'b0001;
    req_data = 32'h00000077;
    n = 0;
    while (m_send !== 1'b1 && n < 8) begin tick(); n++; end
    chk("t7_launch", 32'(m_send), 32'd1);
    tick();
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin tick(); n++; end
    chk("t7_latency", n, 32'd16);
    chk("t7_rsp_err", 32'(rsp_err), 32'd1);
    chk("t7_rsp_data", 32'(rsp_data), 32'h00);
    req = '0;
    tick();
`endif

    chk("grant_invariants", viol, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
